// File: rtl/hex_display_scheduler.sv
// hex_display_scheduler
//   Accepts a six-digit hex value, decodes it one digit at a time through a
//   single shared seven-segment decoder (digit 5 down to 0, DIGIT_CYCLES
//   clocks per digit), then commits all six patterns to the outputs at once.
//
// Ports
//   CLOCK_50    in   clock, all state on rising edge
//   RESET       in   synchronous active-high reset
//   LOAD_VALID  in   requester presents a value
//   LOAD_READY  out  high only in IDLE (and not in reset)
//   LOAD_DATA   in   [23:0] six nibbles, nibble i drives HEXi
//   LOAD_BLANK  in   [5:0]  per-digit force-blank mask
//   LZ_EN       in   leading-zero suppression enable
//   HEX0..HEX5  out  [6:0] active-low segments {g,f,e,d,c,b,a}
//   DONE        out  one-cycle pulse while the commit is presented
module hex_display_scheduler #(
  parameter int unsigned DIGIT_CYCLES = 1
) (
  input  logic        CLOCK_50,
  input  logic        RESET,
  input  logic        LOAD_VALID,
  output logic        LOAD_READY,
  input  logic [23:0] LOAD_DATA,
  input  logic [5:0]  LOAD_BLANK,
  input  logic        LZ_EN,
  output logic [6:0]  HEX0,
  output logic [6:0]  HEX1,
  output logic [6:0]  HEX2,
  output logic [6:0]  HEX3,
  output logic [6:0]  HEX4,
  output logic [6:0]  HEX5,
  output logic        DONE
);

  if (DIGIT_CYCLES == 0 || DIGIT_CYCLES > 255) begin : g_bad_digit_cycles
    $error("hex_display_scheduler: DIGIT_CYCLES must be in 1..255");
  end

  localparam logic [7:0] LAST_CNT = 8'(DIGIT_CYCLES - 1);
  localparam logic [6:0] BLANK    = 7'b1111111;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    COMMIT
  } state_t;

  state_t state, next_state;

  logic [23:0]      shadow_data;
  logic [5:0]       shadow_blank;
  logic             shadow_lz;
  logic [2:0]       idx;
  logic [7:0]       cnt;
  logic             leading;
  logic [5:0][6:0]  staging;
  logic [5:0][6:0]  hex_q;

  logic [3:0]       nib;
  logic [6:0]       glyph;
  logic [6:0]       digit_pat;
  logic             last_cyc;
  logic             accept;

  // Shared decoder, fed by the digit currently being scanned
  always_comb begin
    nib = shadow_data[{idx, 2'b00} +: 4];
    case (nib)
      4'h0: glyph = 7'b1000000;
      4'h1: glyph = 7'b1111001;
      4'h2: glyph = 7'b0100100;
      4'h3: glyph = 7'b0110000;
      4'h4: glyph = 7'b0011001;
      4'h5: glyph = 7'b0010010;
      4'h6: glyph = 7'b0000010;
      4'h7: glyph = 7'b1111000;
      4'h8: glyph = 7'b0000000;
      4'h9: glyph = 7'b0010000;
      4'hA: glyph = 7'b0001000;
      4'hB: glyph = 7'b0000011;
      4'hC: glyph = 7'b1000110;
      4'hD: glyph = 7'b0100001;
      4'hE: glyph = 7'b0000110;
      default: glyph = 7'b0001110;
    endcase
  end

  // Digit 0 is never leading-zero suppressed; the mask always wins
  always_comb begin
    digit_pat = glyph;
    if (shadow_blank[idx] ||
        (shadow_lz && leading && (nib == 4'h0) && (idx != 3'd0))) begin
      digit_pat = BLANK;
    end
  end

  assign last_cyc = (cnt == LAST_CNT);
  assign accept   = (state == IDLE) && LOAD_VALID;

  // FSM: state register
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // FSM: next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (LOAD_VALID) next_state = SCAN;
      SCAN:    if (last_cyc && (idx == 3'd0)) next_state = COMMIT;
      COMMIT:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    LOAD_READY = (state == IDLE) && !RESET;
    DONE       = (state == COMMIT);
  end

  // Datapath
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      shadow_data  <= '0;
      shadow_blank <= '0;
      shadow_lz    <= 1'b0;
      idx          <= '0;
      cnt          <= '0;
      leading      <= 1'b0;
      staging      <= '1;
      hex_q        <= '1;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            shadow_data  <= LOAD_DATA;
            shadow_blank <= LOAD_BLANK;
            shadow_lz    <= LZ_EN;
            idx          <= 3'd5;
            cnt          <= '0;
            leading      <= 1'b1;
          end
        end
        SCAN: begin
          if (last_cyc) begin
            staging[idx] <= digit_pat;
            cnt          <= '0;
            if (nib != 4'h0) leading <= 1'b0;
            if (idx != 3'd0) begin
              idx <= idx - 3'd1;
            end else begin
              // Commit on the same edge that enters COMMIT so HEX and DONE
              // appear together; digit 0 is taken straight from the decoder
              // because its staging slot is being written on this edge too.
              for (int unsigned i = 1; i < 6; i++) begin
                hex_q[i] <= staging[i];
              end
              hex_q[0] <= digit_pat;
            end
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign HEX0 = hex_q[0];
  assign HEX1 = hex_q[1];
  assign HEX2 = hex_q[2];
  assign HEX3 = hex_q[3];
  assign HEX4 = hex_q[4];
  assign HEX5 = hex_q[5];

endmodule
